// File: rtl/pin_filter_pkg.sv
// Shared constants for the pad input filter: register offsets and debounce depth.
package pin_filter_pkg;

  localparam logic [7:0] IE_OFS       = 8'd0;
  localparam logic [7:0] EDGE_OFS     = 8'd1;
  localparam logic [7:0] FLAGS_OFS    = 8'd2;
  localparam logic [7:0] PRESCALE_OFS = 8'd3;
  localparam logic [7:0] CLEAN_OFS    = 8'd4;

  localparam int DEB_TICKS = 4;
  localparam int DEB_W     = 2;

  typedef logic [DEB_W-1:0] deb_cnt_t;

  localparam deb_cnt_t DEB_LAST = deb_cnt_t'(DEB_TICKS - 1);

  function automatic logic reg_hit(input logic [7:0] ofs);
    return ofs <= CLEAN_OFS;
  endfunction

endpackage

// File: rtl/pin_debounce.sv
// One pad input: two-flop synchroniser followed by a tick-driven debounce counter.
module pin_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic changed
);
  import pin_filter_pkg::*;

  logic     s1;
  logic     s2;
  deb_cnt_t cnt;

  // High in the cycle before clean flips, so the top can qualify the edge flag.
  assign changed = tick && (s2 != clean) && (cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == DEB_LAST) begin
          clean <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + deb_cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pin_filter.sv
// Pad input conditioning: per-pin debounce, shared prescaler, edge flags and a small register file.
module pin_filter #(
  parameter logic [7:0] FILTER_ADDRESS = 8'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [7:0] pins_raw,
  output logic [7:0] pins_clean,
  output logic       irq
);
  import pin_filter_pkg::*;

  logic [7:0] ie;
  logic [7:0] edge_sel;
  logic [7:0] flags;
  logic [7:0] prescale;
  logic [7:0] pre_cnt;
  logic       tick;
  logic [7:0] changed;
  logic [7:0] flag_set;
  logic [7:0] flag_clr;
  logic [7:0] ofs;
  logic       hit;
  logic       wr;
  logic       rd;

  assign ofs  = address - FILTER_ADDRESS;
  assign hit  = reg_hit(ofs);
  assign wr   = w_en && hit;
  assign rd   = r_en && hit;
  assign tick = (pre_cnt == prescale);

  for (genvar i = 0; i < 8; i++) begin : g_pin
    pin_debounce u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .raw     (pins_raw[i]),
      .clean   (pins_clean[i]),
      .changed (changed[i])
    );
  end

  // The new clean level is the inverse of the current one, so it matches
  // the selected edge exactly when the current level differs from it.
  assign flag_set = changed & (pins_clean ^ edge_sel);
  assign flag_clr = (wr && ofs == FLAGS_OFS) ? din : 8'h00;
  assign irq      = |(flags & ie);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= 8'h00;
    end else if (wr && ofs == PRESCALE_OFS) begin
      pre_cnt <= 8'h00;
    end else if (tick) begin
      pre_cnt <= 8'h00;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie       <= 8'h00;
      edge_sel <= 8'h00;
      prescale <= 8'h00;
      flags    <= 8'h00;
    end else begin
      if (wr && ofs == IE_OFS)       ie       <= din;
      if (wr && ofs == EDGE_OFS)     edge_sel <= din;
      if (wr && ofs == PRESCALE_OFS) prescale <= din;
      flags <= (flags & ~flag_clr) | flag_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else if (rd) begin
      case (ofs)
        IE_OFS:       dout <= ie;
        EDGE_OFS:     dout <= edge_sel;
        FLAGS_OFS:    dout <= flags;
        PRESCALE_OFS: dout <= prescale;
        default:      dout <= pins_clean;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_filter.sv
// Bench for pin_filter: cycle-level reference model plus directed and randomized stimulus.
module tb_pin_filter;

  localparam logic [7:0] BASE = 8'h04;
  localparam int         DEB  = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] pins_raw;
  logic [7:0] pins_clean;
  logic       irq;

  int passed = 0;
  int total  = 0;

  pin_filter #(.FILTER_ADDRESS(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .address    (address),
    .w_en       (w_en),
    .r_en       (r_en),
    .dout       (dout),
    .pins_raw   (pins_raw),
    .pins_clean (pins_clean),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pads pass through a 2-cycle delay line; a pin's clean level
  // follows the delayed pad once it has disagreed on DEB successive ticks
  // without ever agreeing in between.
  logic [7:0] m_dly1, m_dly2, m_clean, m_ie, m_edge, m_flags, m_prescale, m_dout;
  int         m_pre;
  int         m_run [8];
  logic [7:0] m_ofs, m_set, m_clr, m_next_clean;
  logic       m_hit, m_tick;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_dly1 = 0; m_dly2 = 0; m_clean = 0; m_ie = 0; m_edge = 0;
      m_flags = 0; m_prescale = 0; m_dout = 0; m_pre = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      m_ofs  = address - BASE;
      m_hit  = (m_ofs <= 8'd4);
      m_tick = (m_pre == int'(m_prescale));
      m_set  = 0;
      m_next_clean = m_clean;
      for (int i = 0; i < 8; i++) begin
        if (m_dly2[i] == m_clean[i]) m_run[i] = 0;
        else if (m_tick) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_next_clean[i] = m_dly2[i];
            m_run[i] = 0;
            if (m_dly2[i] == m_edge[i]) m_set[i] = 1'b1;
          end
        end
      end
      if (r_en && m_hit) begin
        case (m_ofs)
          8'd0: m_dout = m_ie;
          8'd1: m_dout = m_edge;
          8'd2: m_dout = m_flags;
          8'd3: m_dout = m_prescale;
          default: m_dout = m_clean;
        endcase
      end
      m_clr = (w_en && m_hit && m_ofs == 8'd2) ? din : 8'h00;
      m_flags = (m_flags & ~m_clr) | m_set;
      if (w_en && m_hit && m_ofs == 8'd3) m_pre = 0;
      else if (m_tick) m_pre = 0;
      else m_pre = m_pre + 1;
      if (w_en && m_hit) begin
        case (m_ofs)
          8'd0: m_ie = din;
          8'd1: m_edge = din;
          8'd3: m_prescale = din;
          default: ;
        endcase
      end
      m_clean = m_next_clean;
      m_dly2 = m_dly1;
      m_dly1 = pins_raw;
    end
    #1;
    check("model_clean", pins_clean, m_clean);
    check("model_dout", dout, m_dout);
    check("model_irq", {7'b0, irq}, {7'b0, |(m_flags & m_ie)});
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    check(name, dout, exp);
  endtask

  int k;

  initial begin
    rst_n = 1'b0; din = 0; address = 0; w_en = 0; r_en = 0; pins_raw = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset_clean", pins_clean, 8'h00);
    check("reset_dout", dout, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);

    rst_n = 1'b1;
    wr(BASE + 8'd1, 8'hFF);
    wr(BASE + 8'd0, 8'h01);
    repeat (3) @(negedge clk);
    check("post_reset_clean_early", pins_clean, 8'h00);
    @(negedge clk);
    check("post_reset_clean_e5", pins_clean, 8'hFF);
    check("post_reset_irq", {7'b0, irq}, 8'h01);
    rd(BASE + 8'd2, 8'hFF, "flags_after_reset");

    wr(BASE + 8'd2, 8'h01);
    check("w1c_irq_low", {7'b0, irq}, 8'h00);
    rd(BASE + 8'd2, 8'hFE, "flags_after_w1c");

    // falling edge on pin 0 lands on the same edge as a W1C of bit 0
    wr(BASE + 8'd1, 8'hFE);
    pins_raw = 8'h00;
    repeat (5) @(negedge clk);
    wr(BASE + 8'd2, 8'h01);
    check("set_beats_w1c_irq", {7'b0, irq}, 8'h01);
    rd(BASE + 8'd2, 8'hFF, "set_beats_w1c_flags");
    check("all_pins_low", pins_clean, 8'h00);

    wr(BASE + 8'd2, 8'hFF);
    wr(BASE + 8'd1, 8'hFF);
    pins_raw = 8'h08;
    repeat (3) @(negedge clk);
    pins_raw = 8'h00;
    repeat (8) @(negedge clk);
    check("pulse3_clean", pins_clean, 8'h00);
    rd(BASE + 8'd2, 8'h00, "pulse3_flags");

    pins_raw = 8'h08;
    repeat (5) @(negedge clk);
    check("hold_clean_e4", pins_clean, 8'h00);
    @(negedge clk);
    check("hold_clean_e5", pins_clean, 8'h08);

    wr(BASE + 8'd3, 8'd9);
    pins_raw = 8'h09;
    k = 0;
    while (k < 60 && !pins_clean[0]) begin
      @(negedge clk);
      k++;
    end
    check("pre9_latency_window", {7'b0, (k >= 33 && k <= 42)}, 8'h01);

    pins_raw = 8'h0B;
    repeat (25) @(negedge clk);
    pins_raw = 8'h09;
    repeat (2) @(negedge clk);
    pins_raw = 8'h0B;
    repeat (15) @(negedge clk);
    check("glitch_restart_low", {7'b0, pins_clean[1]}, 8'h00);
    repeat (40) @(negedge clk);
    check("glitch_restart_high", {7'b0, pins_clean[1]}, 8'h01);

    wr(BASE + 8'd3, 8'd0);
    wr(BASE + 8'd2, 8'hFF);
    wr(BASE + 8'd1, 8'hFB);
    pins_raw = 8'h0F;
    repeat (8) @(negedge clk);
    rd(BASE + 8'd2, 8'h00, "edge2_rise_no_flag");
    pins_raw = 8'h0B;
    repeat (8) @(negedge clk);
    rd(BASE + 8'd2, 8'h04, "edge2_fall_flag");

    rd(BASE + 8'd4, 8'h0B, "read_clean");
    wr(BASE + 8'd4, 8'hFF);
    wr(BASE + 8'd5, 8'hFF);
    wr(BASE - 8'd1, 8'hFF);
    rd(BASE + 8'd0, 8'h01, "ie_untouched");
    rd(BASE + 8'd1, 8'hFB, "edge_untouched");
    rd(BASE + 8'd2, 8'h04, "flags_untouched");
    rd(BASE + 8'd3, 8'h00, "prescale_untouched");
    rd(BASE + 8'd5, 8'h00, "unmapped_read_holds");

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) rst_n = 1'b0;
      if (i == 2003) rst_n = 1'b1;
      if ($urandom_range(0, 9) == 0) pins_raw = pins_raw ^ 8'(1 << $urandom_range(0, 7));
      address = BASE - 8'd1 + 8'($urandom_range(0, 6));
      din     = (address == BASE + 8'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      w_en    = ($urandom_range(0, 9) < 2);
      r_en    = ($urandom_range(0, 9) < 3);
      @(negedge clk);
    end
    w_en = 1'b0; r_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
